axis_uart_tx: RTL and testbench
===============================

// Module: axis_uart_tx
// PURPOSE
//  Serialises bytes from an axis stream onto an asynchronous UART line (8N1 by default).
//  Sits directly downstream of axis_small_fifo / axis_register as the stream sink; transmit only.
//  Accepts a new word only when the previous frame is finishing, so upstream FIFOs absorb bursts.
//  Frames go back-to-back with no idle gap while ivalid stays high.
// PARAMETERS
//  CLOCK_DIV   434  clock cycles per bit (>= 2); 434 = 115200 baud at 50 MHz
//  DATA_BITS   8    data bits per frame (5..9); idata width
//  STOP_BITS   1    stop bits per frame (1 or 2)
//  PARITY_ODD  0    0 = even parity, 1 = odd parity; used only with AXIS_UART_TX_PARITY_EN
// PORTS
//  clock   in   1          rising-edge clock
//  resetn  in   1          asynchronous, active-low reset
//  idata   in   DATA_BITS  word to transmit; sent LSB first
//  ivalid  in   1          idata valid
//  iready  out  1          block accepts idata this cycle
//  txd     out  1          serial line; idle/stop = 1, start = 0; registered
//  busy    out  1          1 while a frame is on the line; registered
// BEHAVIOUR
//  - Reset (async, any state, including mid-frame):
//    - Abort the current frame. The partial frame is lost.
//    - txd=1, busy=0, state=IDLE, bit counter=0, divider=0.
//  - Transfer: a word is taken when ivalid && iready on a rising edge. It is latched into the shift register.
//  - iready is combinational from registers only, never from ivalid. iready is high when:
//    - state==IDLE, or
//    - state==STOP && last stop bit && divider==CLOCK_DIV-1.
//  - FSM transitions:
//    - IDLE -> START on transfer.
//    - START -> DATA.
//    - DATA -> PARITY (when the macro is defined) or STOP, after DATA_BITS bits.
//    - PARITY -> STOP.
//    - STOP -> START on transfer in the final STOP cycle, else STOP -> IDLE.
//  - Bit timing:
//    - Each START/DATA/PARITY/STOP bit drives txd for exactly CLOCK_DIV cycles.
//    - The divider counts 0..CLOCK_DIV-1 and wraps. The bit counter advances on the wrap.
//  - Latency: txd falls (start bit) on the first edge after the transfer.
//    - Frame length = CLOCK_DIV*(1+DATA_BITS+P+STOP_BITS) cycles, where P = 1 if parity is enabled, else 0.
//  - busy: 1 from the cycle after a transfer until the final STOP cycle completes without a new transfer.
//  - idata/ivalid are ignored when iready=0. Holding ivalid does not stall or corrupt the current frame.
//  - Divider width = $clog2(CLOCK_DIV). Bit counter width = $clog2(DATA_BITS+1). No counter overflows.
// CONFIGURATION
//  AXIS_UART_TX_PARITY_EN defined:
//   - A PARITY bit follows the data bits.
//   - Parity value = ^data (even), or ~^data when PARITY_ODD=1.
//   - Parity is computed from the latched word at transfer.
//  AXIS_UART_TX_PARITY_EN undefined:
//   - No PARITY state and no parity logic. PARITY_ODD has no effect.
// STRUCTURE
//  - Shared package uart_pkg:
//    - state encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP (3-bit)
//    - function uart_parity(data, odd)
//  - Sub-module uart_baud_tick: divider with a clear input.
//    - Emits a one-cycle tick at divider==CLOCK_DIV-1.
//    - Cleared on transfer from IDLE.
//    - Reused later by the axis_uart_rx block.
// TESTING
//  Use CLOCK_DIV=4 for all scenarios.
//  1. Send 0x55 once, no parity -> txd = 0,1,0,1,0,1,0,1,0,1, each bit for 4 clocks; total 40 cycles.
//     Then busy=0, iready=1.
//  2. Send 0xA5 then 0x3C with ivalid held high -> second start bit immediately after the first stop bit.
//     No idle cycle; iready pulses 1 cycle per frame.
//  3. Parity enabled, PARITY_ODD=0, send 0x07 -> parity bit 1; frame 44 cycles.
//     Same with PARITY_ODD=1 -> parity bit 0.
//  4. Assert resetn low mid-DATA of 0xFF -> txd=1, busy=0 immediately (async).
//     After release, send 0x00 -> correct full frame.
//  5. STOP_BITS=2, ivalid toggled randomly, 200 words -> scoreboard decodes every byte in order.
//     No word accepted while iready=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity helper shared by the UART tx/rx blocks.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;

   // Zero-extended words up to 9 bits; the padding does not change the XOR.
   function automatic logic uart_parity(input logic [8:0] data, input logic odd);
      return ^data ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider; tick_o marks the last cycle of every bit.
module uart_baud_tick #(
   parameter int CLOCK_DIV = 434
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear_i,
   output logic tick_o
);

   localparam int W = $clog2(CLOCK_DIV);
   localparam logic [W-1:0] LAST = W'(CLOCK_DIV - 1);

   logic [W-1:0] div_q, div_d;

   assign tick_o = div_q == LAST;

   always_comb div_d = clear_i || tick_o ? '0 : div_q + W'(1);

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) div_q <= '0;
      else div_q <= div_d;

endmodule

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: axis sink serialising words onto an async UART line, LSB first.
// Define AXIS_UART_TX_PARITY_EN to append a parity bit (PARITY_ODD selects odd).
module axis_uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_DIV  = 434,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [DATA_BITS-1:0] idata,
   input  logic                 ivalid,
   output logic                 iready,
   output logic                 txd,
   output logic                 busy
);

   localparam int CW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 txd_q, txd_d, busy_q, busy_d;
   logic                 tick, xfer;
`ifdef AXIS_UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_baud_tick #(.CLOCK_DIV(CLOCK_DIV)) u_tick (
      .clock   (clock),
      .resetn  (resetn),
      .clear_i (state_q == S_IDLE),
      .tick_o  (tick)
   );

   // The next word is taken in the final stop cycle so frames abut without a gap.
   assign iready = state_q == S_IDLE || (state_q == S_STOP && cnt_q == LAST_STOP && tick);
   assign xfer   = ivalid && iready;
   assign txd    = txd_q;
   assign busy   = busy_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
`ifdef AXIS_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      if (tick)
         case (state_q)
            S_START: begin
               state_d = S_DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               cnt_d   = '0;
            end
            S_DATA:
               if (cnt_q == LAST_DATA) begin
`ifdef AXIS_UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  txd_d   = parity_q;
`else
                  state_d = S_STOP;
                  txd_d   = 1'b1;
                  cnt_d   = '0;
`endif
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  cnt_d   = cnt_q + CW'(1);
               end
`ifdef AXIS_UART_TX_PARITY_EN
            S_PARITY: begin
               state_d = S_STOP;
               txd_d   = 1'b1;
               cnt_d   = '0;
            end
`endif
            S_STOP:
               if (cnt_q == LAST_STOP) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else cnt_d = cnt_q + CW'(1);
            default: ;
         endcase
      if (xfer) begin
         state_d = S_START;
         txd_d   = 1'b0;
         busy_d  = 1'b1;
         shift_d = idata;
         cnt_d   = '0;
`ifdef AXIS_UART_TX_PARITY_EN
         parity_d = uart_parity(9'(idata), PARITY_ODD);
`endif
      end
   end

   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
`ifdef AXIS_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: line-level model plus directed scenarios for axis_uart_tx.
// u0: 1 stop bit, even parity; u1: 2 stop bits, odd parity (parity only with AXIS_UART_TX_PARITY_EN).
module tb_axis_uart_tx;

   localparam int DIV = 4;
`ifdef AXIS_UART_TX_PARITY_EN
   localparam int P = 1;
   localparam logic [63:0] S1_EXP = 64'h0F0F0F0F00;
`else
   localparam int P = 0;
   localparam logic [63:0] S1_EXP = 64'h0F0F0F0F0F;
`endif
   localparam int FR0 = DIV * (10 + P);
   localparam int FR1 = DIV * (11 + P);

   logic       clock = 1'b0, resetn = 1'b1;
   logic [7:0] idata0 = '0, idata1 = '0;
   logic       ivalid0 = 1'b0, ivalid1 = 1'b0;
   logic       iready0, iready1, txd0, txd1, busy0, busy1;
   int         checks = 0, passed = 0, acc1 = 0, dec1 = 0;
   bit         q0[$], q1[$];
   logic [7:0] words1[$];

   always #5 clock = ~clock;

   axis_uart_tx #(.CLOCK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) u0 (
      .clock(clock), .resetn(resetn), .idata(idata0), .ivalid(ivalid0),
      .iready(iready0), .txd(txd0), .busy(busy0)
   );

   axis_uart_tx #(.CLOCK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b1)) u1 (
      .clock(clock), .resetn(resetn), .idata(idata1), .ivalid(ivalid1),
      .iready(iready1), .txd(txd1), .busy(busy1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Frame bits in line order: start, data LSB first, optional parity, then stop ones.
   function automatic logic [15:0] frame_of(input logic [7:0] d, input logic odd);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
      if (P == 1) f[9] = ^d ^ odd;
      return f;
   endfunction

   // Model: each queue holds the remaining line samples, one per clock; front = current txd.
   initial begin
      bit a0, a1;
      logic [15:0] f0, f1;
      forever begin
         @(posedge clock or negedge resetn);
         if (!resetn) begin
            q0.delete();
            q1.delete();
            words1.delete();
         end else begin
            a0 = ivalid0 && q0.size() <= 1;
            a1 = ivalid1 && q1.size() <= 1;
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
            f0 = frame_of(idata0, 1'b0);
            f1 = frame_of(idata1, 1'b1);
            if (a0)
               for (int i = 0; i < 10 + P; i++)
                  for (int k = 0; k < DIV; k++) q0.push_back(f0[i]);
            if (a1) begin
               for (int i = 0; i < 11 + P; i++)
                  for (int k = 0; k < DIV; k++) q1.push_back(f1[i]);
               words1.push_back(idata1);
               acc1++;
            end
         end
      end
   end

   initial forever begin
      @(negedge clock);
      if (resetn) begin
         chk("txd0", txd0, q0.size() != 0 ? q0[0] : 1'b1);
         chk("busy0", busy0, q0.size() != 0);
         chk("iready0", iready0, q0.size() <= 1);
         chk("txd1", txd1, q1.size() != 0 ? q1[0] : 1'b1);
         chk("busy1", busy1, q1.size() != 0);
         chk("iready1", iready1, q1.size() <= 1);
      end
   end

   // Line receiver on u1: decodes every frame and matches it against the accepted words.
   initial begin
      logic [7:0] d;
      logic [8:0] e;
      forever begin
         @(negedge clock);
         if (resetn && txd1 === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clock);
               d[i] = txd1;
            end
            repeat (DIV) @(negedge clock);
`ifdef AXIS_UART_TX_PARITY_EN
            chk("rx_parity", txd1, ~^d);
            repeat (DIV) @(negedge clock);
`endif
            chk("rx_stop", txd1, 1'b1);
            if (words1.size() != 0) e = {1'b0, words1.pop_front()};
            else e = 9'h1FF;
            chk("rx_word", {1'b0, d}, e);
            dec1++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

   initial begin
      int pulses, a_base, d_base;
      logic [63:0] cap;
      #1 resetn = 1'b0;
      #1;
      chk("rst_txd0", txd0, 1'b1);
      chk("rst_busy0", busy0, 1'b0);
      chk("rst_iready0", iready0, 1'b1);
      chk("rst_txd1", txd1, 1'b1);
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      // single 0x55 frame
      idata0 = 8'h55;
      ivalid0 = 1'b1;
      @(negedge clock);
      ivalid0 = 1'b0;
      cap = '0;
      for (int i = 0; i < 40; i++) begin
         cap[39 - i] = txd0;
         @(negedge clock);
      end
      chk("s1_wave", cap, S1_EXP);
      repeat (P * DIV) @(negedge clock);
      chk("s1_busy_end", busy0, 1'b0);
      chk("s1_iready_end", iready0, 1'b1);
      // back-to-back 0xA5, 0x3C with ivalid held
      repeat (3) @(negedge clock);
      idata0 = 8'hA5;
      ivalid0 = 1'b1;
      @(negedge clock);
      idata0 = 8'h3C;
      pulses = 0;
      for (int i = 0; i < FR0; i++) begin
         pulses += int'(iready0);
         @(negedge clock);
      end
      chk("s2_pulses1", pulses, 1);
      chk("s2_start2", txd0, 1'b0);
      chk("s2_busy2", busy0, 1'b1);
      ivalid0 = 1'b0;
      pulses = 0;
      for (int i = 0; i < FR0; i++) begin
         pulses += int'(iready0);
         @(negedge clock);
      end
      chk("s2_pulses2", pulses, 1);
      chk("s2_idle", busy0, 1'b0);
      // parity on 0x07: even -> 1, odd -> 0
      repeat (2) @(negedge clock);
      idata0 = 8'h07;
      idata1 = 8'h07;
      ivalid0 = 1'b1;
      ivalid1 = 1'b1;
      @(negedge clock);
      ivalid0 = 1'b0;
      ivalid1 = 1'b0;
      repeat (9 * DIV) @(negedge clock);
      chk("s3_par_even", txd0, 1'b1);
      chk("s3_par_odd", txd1, (P == 1) ? 64'd0 : 64'd1);
      repeat (FR0 - 1 - 9 * DIV) @(negedge clock);
      chk("s3_busy_last", busy0, 1'b1);
      @(negedge clock);
      chk("s3_busy_done", busy0, 1'b0);
      repeat (FR1 - FR0 + 2) @(negedge clock);
      // async reset mid-DATA of 0xFF, then a clean 0x00 frame
      idata0 = 8'hFF;
      ivalid0 = 1'b1;
      @(negedge clock);
      ivalid0 = 1'b0;
      repeat (3 * DIV + 2) @(negedge clock);
      chk("s4_busy_pre", busy0, 1'b1);
      #2 resetn = 1'b0;
      #1;
      chk("s4_txd", txd0, 1'b1);
      chk("s4_busy", busy0, 1'b0);
      chk("s4_iready", iready0, 1'b1);
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      idata0 = 8'h00;
      ivalid0 = 1'b1;
      @(negedge clock);
      ivalid0 = 1'b0;
      chk("s4_start", txd0, 1'b0);
      repeat (8 * DIV) @(negedge clock);
      chk("s4_bit7", txd0, 1'b0);
      repeat ((1 + P) * DIV) @(negedge clock);
      chk("s4_stop", txd0, 1'b1);
      repeat (DIV) @(negedge clock);
      chk("s4_done", busy0, 1'b0);
      // 200 words on u1 with random ivalid
      a_base = acc1;
      d_base = dec1;
      for (int n = 0; n < 20000 && acc1 - a_base < 200; n++) begin
         @(negedge clock);
         ivalid1 = 1'($urandom_range(0, 1));
         idata1 = 8'($urandom);
      end
      ivalid1 = 1'b0;
      chk("s5_accepted", acc1 - a_base, 200);
      repeat (FR1 + DIV) @(negedge clock);
      chk("s5_decoded", dec1 - d_base, 200);
      chk("s5_pending", words1.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
